ov7675_cfg_seq: RTL
===================

// Module: ov7675_cfg_seq
// PURPOSE
// Camera register-init sequencer, directly upstream of the i2c master. Walks a table of
// {reg_addr, value} pairs and issues one SCCB 3-phase write per entry to the OV7675 (slave 0x21).
// Also executes table-embedded millisecond delays. Flags done/error to the top level, which gates
// the pixel capture path until done=1.
// PARAMETERS
// TICKS_PER_MS  25000  clk cycles per millisecond (delay timebase)
// PWRUP_MS      10     wait after reset/start before first entry, 1..255
// ROM_DEPTH     128    table entries; index width $clog2(ROM_DEPTH)
// BUSY_TIMEOUT  65535  max clk cycles i2c_busy may stay high per transaction
// AUTO_START    1      1: sequence starts on reset release; 0: waits for start pulse
// PORTS
// clk           in   1       single clock
// rst_n         in   1       asynchronous, active-low reset
// start         in   1       1-cycle pulse; (re)runs sequence from entry 0 when not running
// running       out  1       high from accepted start until done/error
// done          out  1       level, high after END entry or table exhausted; cleared by start
// error         out  1       level, high after handshake/timeout fault; cleared by start
// idx           out  $clog2(ROM_DEPTH)  current table index (debug)
// i2c_din       out  [1:0][7:0]  [1]=reg addr, [0]=value (master sends [1] first)
// i2c_ain       out  8       fixed 8'h21
// i2c_opcode    out  1       fixed 0 (write)
// i2c_ptr_set   out  1       fixed 0
// i2c_vin       out  1       1-cycle request pulse to master
// i2c_busy      in   1       master busy
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE, running=0, done=0, error=0, idx=0, i2c_vin=0,
//   i2c_din=0. Top level must reset master and sequencer together; no drain of in-flight transfer.
// - Table entry 16b: END=16'hFFFF; DELAY={8'hF0, ms}, ms=0 treated as 1; else write {addr, val}.
// - ROM read latency 1 cycle (registered), addressed by idx.
// - FSM:
//   IDLE: AUTO_START (first cycle after reset) or start -> PWRUP, idx<=0, running<=1, done/error<=0.
//   PWRUP: count PWRUP_MS*TICKS_PER_MS cycles -> FETCH.
//   FETCH: 1 cycle for ROM data -> DECODE.
//   DECODE: END -> DONE; DELAY -> DLY (load ms); else latch i2c_din -> ISSUE.
//   ISSUE: when i2c_busy=0 pulse i2c_vin for exactly 1 cycle -> WAIT_HI.
//   WAIT_HI: i2c_busy=1 within 4 cycles -> WAIT_LO, else -> ERR.
//   WAIT_LO: i2c_busy=0 -> NEXT; counter reaching BUSY_TIMEOUT -> ERR.
//   DLY: ms*TICKS_PER_MS cycles -> NEXT.
//   NEXT: idx==ROM_DEPTH-1 -> DONE (no wrap), else idx+1 -> FETCH.
//   DONE: done=1, running=0; start -> PWRUP. ERR: error=1, running=0, idx frozen; start -> PWRUP.
// - i2c_din held stable from ISSUE until WAIT_LO exits; never changes while i2c_busy=1.
// - start while running ignored; start and the cycle done rises coincide -> start wins next cycle.
// - Delay counters: ms counter 8b, tick counter $clog2(TICKS_PER_MS) bits, no overflow past terminal.
// STRUCTURE
// - ov7675_pkg: cfg_entry_t (struct addr/val), CFG_END, CFG_DELAY_ADDR, OV7675_SCCB_ADDR=8'h21,
//   seq state enum.
// - Sub-module ov7675_cfg_rom: case-based synchronous ROM, entry 0 = {8'h12,8'h80} (soft reset)
//   then {F0,0A}.
// TESTING (bench models master busy: rises 1 cycle after vin, stays N cycles)
// - AUTO_START, TICKS_PER_MS=10, PWRUP_MS=2, table {12,80},{F0,01},{11,01},END -> first vin at
//   cycle ~23; two vins total with din 16'h1280 then 16'h1101; 10-cycle gap between; done=1.
// - Model never raises busy after vin -> error=1 4 cycles after vin, idx=0, no further vin.
// - Busy held high > BUSY_TIMEOUT (set 100) -> error=1 at cycle 100; start pulse -> restart, idx=0.
// - Table without END, ROM_DEPTH=4 -> exactly 4 vins, then done=1, idx=3.
// - rst_n low mid-WAIT_LO -> all outputs to reset values same cycle (async); restart after release.
// - start pulse while running -> ignored (vin count unchanged);
//   i2c_din stable across every busy-high window (assertion).

Source files
------------

// File: rtl/ov7675_cfg_seq_pkg.sv
// Shared types and constants for the OV7675 register-init sequencer.
package ov7675_cfg_seq_pkg;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] val;
   } cfg_entry_t;

   localparam logic [15:0] CFG_END          = 16'hFFFF;
   localparam logic [7:0]  CFG_DELAY_ADDR   = 8'hF0;
   localparam logic [7:0]  OV7675_SCCB_ADDR = 8'h21;

   typedef enum logic [3:0] {
      S_IDLE, S_PWRUP, S_FETCH, S_DECODE, S_ISSUE,
      S_WAIT_HI, S_WAIT_LO, S_DLY, S_NEXT, S_DONE, S_ERR
   } seq_state_t;

   function automatic logic is_end(input cfg_entry_t e);
      return e == CFG_END;
   endfunction

   function automatic logic is_delay(input cfg_entry_t e);
      return (e.addr == CFG_DELAY_ADDR);
   endfunction

endpackage

// File: rtl/ov7675_cfg_seq_rom.sv
// Case-based synchronous init table; ROM_SEL picks an alternate short table.
module ov7675_cfg_seq_rom
   import ov7675_cfg_seq_pkg::*;
#(
   parameter int ROM_DEPTH = 128,
   parameter int ROM_SEL   = 0,
   localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   output cfg_entry_t    data
);

   function automatic cfg_entry_t lookup(input int a);
      cfg_entry_t e;
      e = CFG_END;
      if (ROM_SEL == 1) begin
         case (a)
            0: e = {8'h12, 8'h80};
            1: e = {8'hF0, 8'h01};
            2: e = {8'h11, 8'h01};
            default: e = CFG_END;
         endcase
      end else if (ROM_SEL == 2) begin
         case (a)
            0: e = {8'h12, 8'h80};
            1: e = {8'h11, 8'h01};
            2: e = {8'h3A, 8'h04};
            3: e = {8'h40, 8'hD0};
            default: e = CFG_END;
         endcase
      end else begin
         case (a)
            0:  e = {8'h12, 8'h80};   // COM7 soft reset
            1:  e = {8'hF0, 8'h0A};   // let the sensor settle 10 ms
            2:  e = {8'h11, 8'h01};
            3:  e = {8'h3A, 8'h04};
            4:  e = {8'h12, 8'h00};
            5:  e = {8'h17, 8'h13};
            6:  e = {8'h18, 8'h01};
            7:  e = {8'h32, 8'hB6};
            8:  e = {8'h19, 8'h02};
            9:  e = {8'h1A, 8'h7A};
            10: e = {8'h03, 8'h0A};
            11: e = {8'h0C, 8'h00};
            12: e = {8'h3E, 8'h00};
            13: e = {8'h70, 8'h3A};
            14: e = {8'h71, 8'h35};
            15: e = {8'h72, 8'h11};
            16: e = {8'h73, 8'hF0};
            17: e = {8'hA2, 8'h02};
            18: e = {8'h40, 8'hD0};
            default: e = CFG_END;
         endcase
      end
      return e;
   endfunction

   // Registered read: data for idx appears one cycle after it is presented.
   always_ff @(posedge clk) begin
      data <= lookup(int'(addr));
   end

endmodule

// File: rtl/ov7675_cfg_seq.sv
// OV7675 register-init sequencer: walks the table and drives one SCCB write per entry.
module ov7675_cfg_seq
   import ov7675_cfg_seq_pkg::*;
#(
   parameter int TICKS_PER_MS = 25000,
   parameter int PWRUP_MS     = 10,
   parameter int ROM_DEPTH    = 128,
   parameter int BUSY_TIMEOUT = 65535,
   parameter int AUTO_START   = 1,
   parameter int ROM_SEL      = 0,
   localparam int IW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            running,
   output logic            done,
   output logic            error,
   output logic [IW-1:0]   idx,
   output logic [1:0][7:0] i2c_din,
   output logic [7:0]      i2c_ain,
   output logic            i2c_opcode,
   output logic            i2c_ptr_set,
   output logic            i2c_vin,
   input  logic            i2c_busy
);

   localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam int BW = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_MS - 1);
   localparam logic [BW-1:0] BUSY_LAST  = BW'(BUSY_TIMEOUT - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(ROM_DEPTH - 1);
   localparam logic [7:0]    PWRUP_LOAD = 8'(PWRUP_MS);

   seq_state_t    state;
   cfg_entry_t    rom_q;
   logic [TW-1:0] tick;
   logic [7:0]    ms;
   logic [BW-1:0] bcnt;
   logic [1:0]    hcnt;
   logic          armed;    // set by reset so AUTO_START fires exactly once
   logic          restart;  // start that coincided with done rising
   logic          go;

   assign i2c_ain     = OV7675_SCCB_ADDR;
   assign i2c_opcode  = 1'b0;
   assign i2c_ptr_set = 1'b0;

   ov7675_cfg_seq_rom #(.ROM_DEPTH(ROM_DEPTH), .ROM_SEL(ROM_SEL)) u_rom (
      .clk  (clk),
      .addr (idx),
      .data (rom_q)
   );

   // Launch condition: auto/explicit start from IDLE, or a restart from a terminal state.
   always_comb begin
      go = 1'b0;
      if (state == S_IDLE)
         go = (armed && (AUTO_START != 0)) || start;
      else if (state == S_DONE || state == S_ERR)
         go = start || restart;
   end

   // Sequencer FSM with registered outputs and shared ms/tick delay counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         running <= 1'b0;
         done    <= 1'b0;
         error   <= 1'b0;
         idx     <= '0;
         i2c_vin <= 1'b0;
         i2c_din <= '0;
         tick    <= '0;
         ms      <= '0;
         bcnt    <= '0;
         hcnt    <= '0;
         armed   <= 1'b1;
         restart <= 1'b0;
      end else begin
         i2c_vin <= 1'b0;
         if (go) begin
            state   <= S_PWRUP;
            idx     <= '0;
            running <= 1'b1;
            done    <= 1'b0;
            error   <= 1'b0;
            tick    <= '0;
            ms      <= PWRUP_LOAD;
            armed   <= 1'b0;
            restart <= 1'b0;
         end else begin
            case (state)
               S_PWRUP, S_DLY: begin
                  if (tick == TICK_LAST) begin
                     tick <= '0;
                     if (ms <= 8'd1)
                        state <= (state == S_PWRUP) ? S_FETCH : S_NEXT;
                     else
                        ms <= ms - 8'd1;
                  end else begin
                     tick <= tick + 1'b1;
                  end
               end
               S_FETCH: state <= S_DECODE;
               S_DECODE: begin
                  if (is_end(rom_q)) begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     running <= 1'b0;
                     restart <= start;
                  end else if (is_delay(rom_q)) begin
                     state <= S_DLY;
                     tick  <= '0;
                     ms    <= (rom_q.val == 8'd0) ? 8'd1 : rom_q.val;
                  end else begin
                     i2c_din <= {rom_q.addr, rom_q.val};
                     state   <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  if (!i2c_busy) begin
                     i2c_vin <= 1'b1;
                     hcnt    <= '0;
                     state   <= S_WAIT_HI;
                  end
               end
               S_WAIT_HI: begin
                  if (i2c_busy) begin
                     bcnt  <= '0;
                     state <= S_WAIT_LO;
                  end else if (hcnt == 2'd3) begin
                     state   <= S_ERR;
                     error   <= 1'b1;
                     running <= 1'b0;
                  end else begin
                     hcnt <= hcnt + 1'b1;
                  end
               end
               S_WAIT_LO: begin
                  if (!i2c_busy) begin
                     state <= S_NEXT;
                  end else if (bcnt == BUSY_LAST) begin
                     state   <= S_ERR;
                     error   <= 1'b1;
                     running <= 1'b0;
                  end else begin
                     bcnt <= bcnt + 1'b1;
                  end
               end
               S_NEXT: begin
                  if (idx == IDX_LAST) begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     running <= 1'b0;
                     restart <= start;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= S_FETCH;
                  end
               end
               S_DONE, S_ERR, S_IDLE: state <= state;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
